// File: rtl/in_class_pkg.sv
// Shared types and helpers for the in-class teaching datapath.
package in_class_pkg;

   localparam int WIDTH_DEF = 16;

   typedef logic [WIDTH_DEF-1:0] word_t;

   // Unsigned add that clamps to all-ones instead of wrapping.
   function automatic word_t sat_add(input word_t i_a, input word_t i_b);
      logic [WIDTH_DEF:0] w_s;
      w_s = {1'b0, i_a} + {1'b0, i_b};
      return w_s[WIDTH_DEF] ? {WIDTH_DEF{1'b1}} : w_s[WIDTH_DEF-1:0];
   endfunction

endpackage

// File: rtl/in_class_max3.sv
// Combinational unsigned maximum of three operands; ties return the shared value.
module in_class_max3 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   output logic [WIDTH-1:0] o_max
);

   logic [WIDTH-1:0] w_ab;

   assign w_ab  = (i_a >= i_b) ? i_a : i_b;
   assign o_max = (w_ab >= i_c) ? w_ab : i_c;

endmodule

// File: rtl/in_class_core.sv
// Registered 3-input datapath: x = a+b, y = running sum of c, z = max(a,b,c).
// Define IN_CLASS_CORE_SAT_EN to make x and y saturate instead of wrapping.
module in_class_core
   import in_class_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   logic [WIDTH-1:0] r_x, r_y, r_z;
   logic [WIDTH-1:0] w_sum, w_acc, w_max;

`ifdef IN_CLASS_CORE_SAT_EN
   // Saturating build relies on the package word width.
   assign w_sum = WIDTH'(sat_add(word_t'(a), word_t'(b)));
   assign w_acc = WIDTH'(sat_add(word_t'(r_y), word_t'(c)));
`else
   assign w_sum = a + b;
   assign w_acc = r_y + c;
`endif

   in_class_max3 #(.WIDTH(WIDTH)) u_max3 (
      .i_a   (a),
      .i_b   (b),
      .i_c   (c),
      .o_max (w_max)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_x <= '0;
         r_y <= '0;
         r_z <= '0;
      end else begin
         r_x <= w_sum;
         r_y <= w_acc;
         r_z <= w_max;
      end
   end

   assign x = r_x;
   assign y = r_y;
   assign z = r_z;

endmodule

// File: tb/tb_in_class_core.sv
// Self-checking bench for in_class_core; a scoreboard queue holds expected x/y/z per edge.
module tb_in_class_core;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] a, b, c;
   logic [15:0] x, y, z;

   exp_t        sb[$];
   logic [15:0] m_y;
   int          n_cmp;
   int          n_bad;

   in_class_core dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .c     (c),
      .x     (x),
      .y     (y),
      .z     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] m_add(input logic [15:0] p, input logic [15:0] q);
      logic [16:0] s;
      s = {1'b0, p} + {1'b0, q};
`ifdef IN_CLASS_CORE_SAT_EN
      if (s[16]) return 16'hFFFF;
`endif
      return s[15:0];
   endfunction

   function automatic logic [15:0] m_max(input logic [15:0] p, input logic [15:0] q,
                                         input logic [15:0] r);
      logic [15:0] m;
      m = p;
      if (q > m) m = q;
      if (r > m) m = r;
      return m;
   endfunction

   // Apply one edge of stimulus: push the model's prediction, then step past the edge.
   task automatic drive(input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] ic, input logic rst);
      exp_t e;
      a = ia; b = ib; c = ic; reset = rst;
      if (!rst) begin
         m_y = 16'h0;
         e   = '0;
      end else begin
         m_y = m_add(m_y, ic);
         e.x = m_add(ia, ib);
         e.y = m_y;
         e.z = m_max(ia, ib, ic);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         drive(16'h1234, 16'h1111, 16'h0005, 1'b0);
         e = sb.pop_front();
         n_cmp++;
         if ({x, y, z} !== 48'h0 || {x, y, z} !== e) begin
            n_bad++;
            $display("FAIL reset[%0d]: got x=%h y=%h z=%h, want all zero", k, x, y, z);
         end
      end
   endtask

   task automatic test_sum_sweep();
      exp_t        e;
      logic [15:0] v;
      int          bad_here;
      bad_here = 0;
      for (int i = 0; i < 65536; i++) begin
         v = i[15:0];
         drive(v, ~v, 16'h0000, 1'b1);
         e = sb.pop_front();
         n_cmp++;
         if (x !== 16'hFFFF || x !== e.x) begin
            n_bad++;
            if (bad_here < 5)
               $display("FAIL sum_sweep i=%0d: got x=%h, want ffff", i, x);
            bad_here++;
         end
      end
   endtask

   task automatic test_accumulate();
      exp_t e;
      drive(16'h0, 16'h0, 16'h0, 1'b0);
      void'(sb.pop_front());
      for (int k = 1; k <= 4; k++) begin
         drive(16'h0000, 16'h0000, 16'h0003, 1'b1);
         e = sb.pop_front();
         n_cmp++;
         if (y !== 16'(3 * k) || {x, y, z} !== e) begin
            n_bad++;
            $display("FAIL accumulate[%0d]: got y=%h, want %h", k, y, 16'(3 * k));
         end
      end
   endtask

   task automatic test_wrap();
      exp_t        e;
      logic [15:0] want;
      drive(16'h0, 16'h0, 16'h0, 1'b0);
      void'(sb.pop_front());
      drive(16'h0, 16'h0, 16'hFFFE, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (y !== 16'hFFFE || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL wrap_preload: got y=%h, want fffe", y);
      end
`ifdef IN_CLASS_CORE_SAT_EN
      want = 16'hFFFF;
`else
      want = 16'h0003;
`endif
      drive(16'h0, 16'h0, 16'h0005, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (y !== want || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL wrap_y: got y=%h, want %h", y, want);
      end
      // Saturated accumulator must stay pinned; wrapped one just adds.
      drive(16'h0, 16'h0, 16'h0001, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (y !== m_add(want, 16'h0001) || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL wrap_hold: got y=%h, want %h", y, m_add(want, 16'h0001));
      end
`ifdef IN_CLASS_CORE_SAT_EN
      want = 16'hFFFF;
`else
      want = 16'h0001;
`endif
      drive(16'hFFFF, 16'h0002, 16'h0000, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (x !== want || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL wrap_x: got x=%h, want %h", x, want);
      end
   endtask

   task automatic test_max();
      exp_t e;
      drive(16'h0010, 16'h8000, 16'h7FFF, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (z !== 16'h8000 || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL max_mixed: got z=%h, want 8000", z);
      end
      drive(16'h00AA, 16'h00AA, 16'h00AA, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (z !== 16'h00AA || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL max_tie: got z=%h, want 00aa", z);
      end
      drive(16'h0001, 16'h0002, 16'hF000, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (z !== 16'hF000 || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL max_c: got z=%h, want f000", z);
      end
   endtask

   task automatic test_midrun_reset();
      exp_t e;
      drive(16'h0, 16'h0, 16'h0, 1'b0);
      void'(sb.pop_front());
      for (int k = 0; k < 3; k++) begin
         drive(16'h0, 16'h0, 16'h0100, 1'b1);
         void'(sb.pop_front());
      end
      n_cmp++;
      if (y !== 16'h0300) begin
         n_bad++;
         $display("FAIL midrun_acc: got y=%h, want 0300", y);
      end
      drive(16'h0, 16'h0, 16'h0100, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (y !== 16'h0000 || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL midrun_reset: got y=%h, want 0000", y);
      end
      drive(16'h0, 16'h0, 16'h0001, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if (y !== 16'h0001 || {x, y, z} !== e) begin
         n_bad++;
         $display("FAIL midrun_release: got y=%h, want 0001", y);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic rst;
      for (int k = 0; k < 300; k++) begin
         rst = ($urandom_range(0, 19) != 0);
         drive(16'($urandom), 16'($urandom), 16'($urandom), rst);
         e = sb.pop_front();
         n_cmp++;
         if ({x, y, z} !== e) begin
            n_bad++;
            $display("FAIL back_to_back[%0d]: got x=%h y=%h z=%h, want x=%h y=%h z=%h",
                     k, x, y, z, e.x, e.y, e.z);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      m_y   = 16'h0;
      reset = 1'b0;
      a = 16'h0; b = 16'h0; c = 16'h0;
      test_reset();
      test_sum_sweep();
      test_accumulate();
      test_wrap();
      test_max();
      test_midrun_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
